// File: rtl/chip_chk_pkg.sv
// Shared types and default sizing for the chip-checker front-end sequencer.
package chip_chk_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        SHOW   = 3'd4
    } seq_state_t;

    localparam int unsigned DEF_NUM_CHIPS      = 8;
    localparam int unsigned DEF_SEL_W          = 3;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1048576;
    localparam int unsigned DEF_CNT_W          = 20;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button level, followed by a
// one-cycle rising-edge pulse. Holding the button produces a single pulse.
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/chip_test_sequencer.sv
// Launches the selected chip tester, waits for Done or timeout, samples the
// result and holds Pass/Fail/Timeout/Err until the next Start.
//
//   state  | meaning
//   IDLE   | after reset, waiting for Start
//   LAUNCH | one cycle, Run asserted, timeout counter cleared
//   WAIT   | Run held, waiting for selected Done or timeout
//   SAMPLE | one cycle, DISP_RSLT asserted, result captured
//   SHOW   | result flags held, waiting for Start
module chip_test_sequencer
    import chip_chk_pkg::*;
#(
    parameter int unsigned NUM_CHIPS      = DEF_NUM_CHIPS,
    parameter int unsigned SEL_W          = DEF_SEL_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [SEL_W-1:0]     Sel,
    input  logic [NUM_CHIPS-1:0] Done_vec,
    input  logic [NUM_CHIPS-1:0] RSLT_vec,
    output logic [NUM_CHIPS-1:0] Run_vec,
    output logic [NUM_CHIPS-1:0] Disp_vec,
    output logic                 Busy,
    output logic                 Pass,
    output logic                 Fail,
    output logic                 Timeout,
    output logic                 Err,
    output logic [SEL_W-1:0]     Sel_q
);

    localparam logic [NUM_CHIPS-1:0] ONE_LSB  = NUM_CHIPS'(1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SEL_W-1:0]     sel_lat_q, sel_lat_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic                 timeout_q, timeout_d;
    logic                 err_q, err_d;
    logic [NUM_CHIPS-1:0] run_q, run_d;
    logic [NUM_CHIPS-1:0] disp_q, disp_d;

    logic                 start_pulse;
    logic                 sel_err;
    logic [NUM_CHIPS-1:0] sel_oh_q;
    logic [NUM_CHIPS-1:0] sel_oh_d;
    logic                 done_sel;
    logic                 rslt_sel;

    btn_sync_edge u_start_sync (
        .clk_i   (Clk),
        .rst_n_i (Reset),
        .btn_i   (Start),
        .pulse_o (start_pulse)
    );

    assign sel_err  = (32'(Sel) >= NUM_CHIPS);
    assign sel_oh_q = ONE_LSB << sel_lat_q;
    assign done_sel = |(Done_vec & sel_oh_q);
    assign rslt_sel = |(RSLT_vec & sel_oh_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_lat_d = sel_lat_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        err_d     = err_q;

        case (state_q)
            IDLE, SHOW: begin
                if (start_pulse) begin
                    sel_lat_d = Sel;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                    err_d     = 1'b0;
                    if (sel_err) begin
                        state_d = SHOW;
                        err_d   = 1'b1;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Done is tested first so it wins over a coincident terminal count.
                if (done_sel) begin
                    state_d = SAMPLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = SHOW;
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                pass_d  = rslt_sel;
                fail_d  = ~rslt_sel;
                state_d = SHOW;
            end
            default: state_d = IDLE;
        endcase

        // Run/Disp are registered from the next state so they line up with it.
        sel_oh_d = ONE_LSB << sel_lat_d;
        run_d    = (state_d == LAUNCH || state_d == WAIT) ? sel_oh_d : '0;
        disp_d   = (state_d == SAMPLE) ? sel_oh_d : '0;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_lat_q <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            run_q     <= '0;
            disp_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_lat_q <= sel_lat_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            run_q     <= run_d;
            disp_q    <= disp_d;
        end
    end

    assign Run_vec  = run_q;
    assign Disp_vec = disp_q;
    assign Busy     = (state_q == LAUNCH) || (state_q == WAIT) || (state_q == SAMPLE);
    assign Pass     = pass_q;
    assign Fail     = fail_q;
    assign Timeout  = timeout_q;
    assign Err      = err_q;
    assign Sel_q    = sel_lat_q;

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Randomised self-checking bench for chip_test_sequencer against a
// cycle-count reference model of the test sequence.
module tb_chip_test_sequencer;

    localparam int NC = 6;
    localparam int SW = 3;
    localparam int T  = 16;
    localparam int CW = 5;
    localparam int NEVER = 1000;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic [SW-1:0] Sel;
    logic [NC-1:0] Done_vec;
    logic [NC-1:0] RSLT_vec;
    logic [NC-1:0] Run_vec;
    logic [NC-1:0] Disp_vec;
    logic          Busy;
    logic          Pass;
    logic          Fail;
    logic          Timeout;
    logic          Err;
    logic [SW-1:0] Sel_q;

    int n_checks = 0;
    int n_errors = 0;
    int start_left = 0;

    chip_test_sequencer #(
        .NUM_CHIPS      (NC),
        .SEL_W          (SW),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (CW)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Sel      (Sel),
        .Done_vec (Done_vec),
        .RSLT_vec (RSLT_vec),
        .Run_vec  (Run_vec),
        .Disp_vec (Disp_vec),
        .Busy     (Busy),
        .Pass     (Pass),
        .Fail     (Fail),
        .Timeout  (Timeout),
        .Err      (Err),
        .Sel_q    (Sel_q)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
        if (start_left > 0) begin
            start_left--;
            if (start_left == 0) Start = 1'b0;
        end
    endtask

    task automatic check_flags(input string tag, input bit p, input bit f, input bit t, input bit e);
        check_eq({tag, "_pass"}, Pass, p);
        check_eq({tag, "_fail"}, Fail, f);
        check_eq({tag, "_timeout"}, Timeout, t);
        check_eq({tag, "_err"}, Err, e);
    endtask

    task automatic release_start();
        int guard = 0;
        while (start_left > 0 && guard < 20) begin
            step();
            guard++;
        end
        Start = 1'b0;
        step();
        step();
    endtask

    // d: Run-cycle index (0 = LAUNCH cycle) from which the selected Done is high.
    task automatic do_test(input int sel, input int d, input bit rslt, input bit noise);
        int lat;
        int run_len;
        int exp_len;
        bit exp_done;
        logic [NC-1:0] exp_oh;

        exp_oh   = NC'(1) << sel;
        Done_vec = '0;
        RSLT_vec = NC'($urandom);
        if (sel < NC) RSLT_vec[sel] = rslt;
        Sel        = SW'(sel);
        Start      = 1'b1;
        start_left = $urandom_range(1, 4);

        if (sel >= NC) begin
            for (int i = 0; i < 5; i++) begin
                step();
                check_eq("err_run", Run_vec, 0);
                check_eq("err_disp", Disp_vec, 0);
            end
            check_flags("err", 1'b0, 1'b1, 1'b0, 1'b1);
            check_eq("err_busy", Busy, 0);
            check_eq("err_selq", Sel_q, sel);
            release_start();
            return;
        end

        lat = 0;
        while (Run_vec == 0 && lat < 8) begin
            step();
            lat++;
        end
        check_eq("launch_lat_ok", (lat >= 1 && lat <= 3), 1);

        exp_done = (d <= T);
        exp_len  = exp_done ? ((d < 1 ? 1 : d) + 1) : (T + 1);
        run_len  = 0;
        while (Run_vec != 0 && run_len < T + 10) begin
            check_eq("run_onehot", Run_vec, exp_oh);
            check_eq("run_disp0", Disp_vec, 0);
            check_eq("run_busy", Busy, 1);
            Done_vec      = '0;
            Done_vec[sel] = (run_len >= d);
            if (noise) begin
                Done_vec = (Done_vec & exp_oh) | (NC'($urandom) & ~exp_oh);
                Sel      = SW'($urandom);
                if (run_len == 2 && exp_len > 8 && start_left == 0) begin
                    Start      = 1'b1;
                    start_left = 1;
                end
            end
            run_len++;
            step();
        end
        check_eq("run_len", run_len, exp_len);

        if (exp_done) begin
            check_eq("sample_disp", Disp_vec, exp_oh);
            check_eq("sample_run0", Run_vec, 0);
            check_eq("sample_busy", Busy, 1);
            RSLT_vec = NC'($urandom);
            RSLT_vec[sel] = rslt;
            step();
            check_eq("show_disp0", Disp_vec, 0);
            check_flags("done", rslt, !rslt, 1'b0, 1'b0);
        end else begin
            check_eq("to_disp0", Disp_vec, 0);
            check_flags("to", 1'b0, 1'b1, 1'b1, 1'b0);
        end
        check_eq("show_busy", Busy, 0);
        check_eq("show_selq", Sel_q, sel);
        Done_vec = '0;
        RSLT_vec = NC'($urandom);
        release_start();
        check_eq("hold_run0", Run_vec, 0);
        check_eq("hold_pass", Pass, exp_done && rslt);
        check_eq("hold_fail", Fail, !(exp_done && rslt));
    endtask

    initial begin
        int launches;
        logic [NC-1:0] prev_run;

        Reset    = 1'b0;
        Start    = 1'b0;
        Sel      = '0;
        Done_vec = '0;
        RSLT_vec = '0;
        #23;
        check_eq("rst_run", Run_vec, 0);
        check_eq("rst_disp", Disp_vec, 0);
        check_eq("rst_busy", Busy, 0);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_selq", Sel_q, 0);
        @(negedge Clk);
        Reset = 1'b1;
        step();
        step();

        do_test(3, 10, 1'b1, 1'b0);
        do_test(0, 4, 1'b0, 1'b1);
        do_test(1, NEVER, 1'b0, 1'b0);
        do_test(1, T, 1'b1, 1'b0);
        do_test(1, T + 1, 1'b1, 1'b0);
        do_test(4, 0, 1'b0, 1'b0);
        do_test(5, 1, 1'b1, 1'b1);
        do_test(7, 3, 1'b1, 1'b0);

        // Start held high after an Err result: exactly one launch.
        Sel        = 3'd2;
        Done_vec   = '0;
        Start      = 1'b1;
        start_left = 0;
        launches   = 0;
        prev_run   = Run_vec;
        for (int i = 0; i < 100; i++) begin
            step();
            if (prev_run == 0 && Run_vec != 0) launches++;
            prev_run = Run_vec;
        end
        check_eq("held_launches", launches, 1);
        check_flags("held", 1'b0, 1'b1, 1'b1, 1'b0);
        Start = 1'b0;
        step();
        step();

        // Reset asserted five cycles into WAIT.
        Sel        = 3'd2;
        Start      = 1'b1;
        start_left = 1;
        for (int i = 0; i < 8 && Run_vec == 0; i++) step();
        for (int i = 0; i < 6; i++) step();
        check_eq("pre_rst_run", Run_vec, 6'h04);
        #3;
        Reset = 1'b0;
        #1;
        check_eq("midrst_run", Run_vec, 0);
        check_eq("midrst_busy", Busy, 0);
        check_flags("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("midrst_selq", Sel_q, 0);
        start_left = 0;
        Start = 1'b0;
        step();
        @(negedge Clk);
        Reset = 1'b1;
        step();
        check_eq("postrst_busy", Busy, 0);
        check_eq("postrst_run", Run_vec, 0);
        do_test(2, 7, 1'b1, 1'b0);

        for (int k = 0; k < 30; k++) begin
            int s;
            int dd;
            s  = $urandom_range(0, 7);
            dd = ($urandom_range(0, 4) == 0) ? NEVER : $urandom_range(0, T + 2);
            do_test(s, dd, 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/chip_test_sequencer.md
Name: chip_test_sequencer

Overview:
Front-end controller for the chip-checker tester modules (chip_74xx family). It synchronises the Start button, latches the chip selection and launches the selected tester with a one-hot Run. It then waits for that tester's Done, with a timeout, and strobes DISP_RSLT to sample its pass/fail result. Pass/Fail/Timeout/Err are held for the display logic until the next Start.

Parameters:
NUM_CHIPS, 8, number of tester slots driven; one-hot Run/DISP_RSLT width.
SEL_W, 3, width of chip-select input; must satisfy 2**SEL_W >= NUM_CHIPS.
TIMEOUT_CYCLES, 1048576, max cycles spent in WAIT before declaring timeout; must be >= 2.
CNT_W, 20, width of timeout counter; must satisfy 2**CNT_W >= TIMEOUT_CYCLES.

Ports:
Clk  input  1  system clock; all state on rising edge.
Reset  input  1  asynchronous, active-low reset.
Start  input  1  raw push-button level; asynchronous to Clk.
Sel  input  SEL_W  chip-select switches; sampled only on a Start edge in IDLE/SHOW.
Done_vec  input  NUM_CHIPS  per-tester Done levels.
RSLT_vec  input  NUM_CHIPS  per-tester RSLT; valid while that tester's DISP_RSLT is high.
Run_vec  output  NUM_CHIPS  one-hot Run to selected tester.
Disp_vec  output  NUM_CHIPS  one-hot DISP_RSLT to selected tester.
Busy  output  1  high in LAUNCH, WAIT and SAMPLE.
Pass  output  1  last test passed.
Fail  output  1  last test failed, timed out, or had a bad selection.
Timeout  output  1  last test hit TIMEOUT_CYCLES.
Err  output  1  last Sel was >= NUM_CHIPS.
Sel_q  output  SEL_W  latched selection of last or current test.

Behaviour:
- Reset low (async): state=IDLE; all outputs 0; sync flops, counter and Sel_q cleared.
- Start path: 2-flop synchroniser, then rising-edge detect. start_pulse is 1 cycle, 3 cycles after the raw edge at worst. Start held high produces a single pulse.
- IDLE / SHOW + start_pulse:
  - Sel_q <= Sel; Pass/Fail/Timeout/Err cleared.
  - If Sel >= NUM_CHIPS: go to SHOW with Err=1, Fail=1.
  - Otherwise go to LAUNCH.
- LAUNCH (1 cycle): Run_vec[Sel_q]=1; counter <= 0; go to WAIT.
- WAIT:
  - Run_vec[Sel_q]=1 held; counter increments each cycle.
  - Done_vec[Sel_q]=1: go to SAMPLE, Run dropped next cycle. Done is checked before timeout, so Done in the same cycle as terminal count wins.
  - Otherwise, counter == TIMEOUT_CYCLES-1: go to SHOW with Timeout=1, Fail=1.
  - Done bits of non-selected slots are ignored.
- SAMPLE (1 cycle): Run_vec=0; Disp_vec[Sel_q]=1. At the end of the cycle, Pass <= RSLT_vec[Sel_q] and Fail <= ~RSLT_vec[Sel_q]; go to SHOW.
- SHOW: Pass/Fail/Timeout/Err held; Run_vec=Disp_vec=0. Leaves only on start_pulse, which restarts as from IDLE.
- start_pulse during LAUNCH/WAIT/SAMPLE is ignored (no abort, no queueing).
- Run_vec and Disp_vec are registered outputs, never multi-hot, and never both non-zero in the same cycle.
- Changes to Sel outside a start_pulse do not affect the test in progress.
- Reset asserted mid-test returns to IDLE immediately and drops Run/Disp asynchronously.
- Busy = state in {LAUNCH, WAIT, SAMPLE}.
- Pass and Fail are never both 1. After any completed test, exactly one of them is 1.

Decomposition:
- Package chip_chk_pkg: state enum seq_state_t {IDLE, LAUNCH, WAIT, SAMPLE, SHOW} and default NUM_CHIPS / TIMEOUT_CYCLES constants.
- One sub-module: btn_sync_edge (2-flop synchroniser plus rising-edge pulse, async active-low reset), reusable for other buttons.
- Timeout counter and FSM stay in the top module.

Test Plan:
- Reset mid-WAIT (Sel=2, Start, assert Reset low 5 cycles into WAIT) -> Run_vec=0 and all flags 0 immediately. After release, state is IDLE; a new Start with Sel=2 runs normally.
- Sel=3, Start, model raises Done_vec[3] 10 cycles after Run, RSLT_vec[3]=1 while Disp high -> Run_vec=8'h08 for 11 cycles (LAUNCH plus 10 WAIT). Then Disp_vec=8'h08 for 1 cycle; Pass=1, Fail=0, Busy=0, Sel_q=3.
- Sel=0, Done after 4 cycles, RSLT=0; during WAIT toggle Done_vec[5] and change Sel to 5 -> only Done_vec[0] ends WAIT; Sel_q stays 0; Fail=1, Pass=0.
- TIMEOUT_CYCLES=16, Sel=1, no Done -> Run high 17 cycles (LAUNCH plus 16 WAIT); then Timeout=1, Fail=1, Disp_vec never asserted.
- TIMEOUT_CYCLES=16, Done_vec[1] rises exactly on the terminal-count cycle -> goes to SAMPLE, Timeout=0, result taken from RSLT.
- NUM_CHIPS=6, Sel=7, Start -> SHOW directly with Err=1, Fail=1; Run_vec never asserted. Start held high 100 cycles afterwards -> exactly one restart.
